// File: rtl/response_resolver.sv
// Multiple-response resolver: captures CAM match lines and emits responder indices in ascending
// order over a valid/ready handshake. Define RESPONSE_RESOLVER_COUNT_EN to enable resp_count.
module response_resolver #(
  parameter int unsigned WORDS = 100,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORDS-1:0] match_lines,
  input  logic             load,
  output logic             busy,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] resp_idx,
  output logic             done,
  output logic [IDX_W-1:0] resp_count
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [WORDS-1:0] tag_q, tag_d;
  logic [WORDS-1:0] lowest;
  logic [WORDS-1:0] remaining;
  logic [IDX_W-1:0] enc;

  // Isolate the lowest set tag bit (two's-complement trick).
  assign lowest    = tag_q & (~tag_q + WORDS'(1));
  assign remaining = tag_q & ~lowest;

  // Priority encoder: the last assignment wins, so scan downwards to keep the lowest index.
  always_comb begin
    enc = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (tag_q[i]) enc = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          tag_d   = ~match_lines;
          state_d = (&match_lines) ? StDone : StScan;
        end
      end
      StScan: begin
        if (idx_ready) begin
          tag_d = remaining;
          if (remaining == '0) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign idx_valid = (state_q == StScan);
  assign resp_idx  = (state_q == StScan) ? enc : '0;
  assign done      = (state_q == StDone);

`ifdef RESPONSE_RESOLVER_COUNT_EN
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WORDS; i++) begin
      pop = pop + IDX_W'(~match_lines[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (state_q == StIdle && load) begin
      count_q <= pop;
    end
  end

  assign resp_count = count_q;
`else
  assign resp_count = '0;
`endif

endmodule

// File: tb/tb_response_resolver.sv
// Directed bench for response_resolver: table of load cases plus hand-written sequences for
// backpressure, load during scan and reset mid-scan.
module tb_response_resolver;

  localparam int unsigned WORDS = 100;
  localparam int unsigned IDX_W = 7;
`ifdef RESPONSE_RESOLVER_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [WORDS-1:0] match_lines;
  logic             load;
  logic             busy;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDX_W-1:0] resp_idx;
  logic             done;
  logic [IDX_W-1:0] resp_count;

  int total = 0;
  int bad   = 0;

  response_resolver #(
    .WORDS(WORDS),
    .IDX_W(IDX_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .match_lines(match_lines),
    .load       (load),
    .busy       (busy),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .resp_idx   (resp_idx),
    .done       (done),
    .resp_count (resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][6:0]  idx;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [WORDS-1:0] mk_ml(input vec_t v);
    logic [WORDS-1:0] ml;
    ml = '1;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(v.n)) ml[v.idx[k]] = 1'b0;
    end
    return ml;
  endfunction

  function automatic int exp_cnt(input int n);
    return CountEn ? n : 0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  vec_t v149;

  initial begin
    rst         = 1'b1;
    load        = 1'b0;
    match_lines = '1;
    idx_ready   = 1'b0;

    vecs[0] = '{n: 3'd0, idx: '{7'd0, 7'd0, 7'd0, 7'd0}};
    vecs[1] = '{n: 3'd3, idx: '{7'd0, 7'd99, 7'd4, 7'd1}};
    vecs[2] = '{n: 3'd1, idx: '{7'd0, 7'd0, 7'd0, 7'd0}};
    vecs[3] = '{n: 3'd1, idx: '{7'd0, 7'd0, 7'd0, 7'd99}};
    vecs[4] = '{n: 3'd4, idx: '{7'd99, 7'd98, 7'd1, 7'd0}};
    v149    = vecs[1];

    // Reset held for two edges
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(idx_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(resp_count), 0);
    chk("rst_idx", 32'(resp_idx), 0);
    rst = 1'b0;
    tick();

    // Table-driven load cases with idx_ready held high
    for (int c = 0; c < 5; c++) begin
      match_lines = mk_ml(vecs[c]);
      load        = 1'b1;
      idx_ready   = 1'b1;
      tick();
      load        = 1'b0;
      match_lines = '1;
      for (int k = 0; k < int'(vecs[c].n); k++) begin
        chk($sformatf("c%0d_valid%0d", c, k), 32'(idx_valid), 1);
        chk($sformatf("c%0d_idx%0d", c, k), 32'(resp_idx), 32'(vecs[c].idx[k]));
        chk($sformatf("c%0d_done%0d", c, k), 32'(done), 0);
        tick();
      end
      chk($sformatf("c%0d_done", c), 32'(done), 1);
      chk($sformatf("c%0d_busy_done", c), 32'(busy), 1);
      chk($sformatf("c%0d_valid_done", c), 32'(idx_valid), 0);
      chk($sformatf("c%0d_idx_done", c), 32'(resp_idx), 0);
      chk($sformatf("c%0d_count", c), 32'(resp_count), 32'(exp_cnt(int'(vecs[c].n))));
      tick();
      chk($sformatf("c%0d_idle_busy", c), 32'(busy), 0);
      chk($sformatf("c%0d_idle_done", c), 32'(done), 0);
      chk($sformatf("c%0d_count_hold", c), 32'(resp_count), 32'(exp_cnt(int'(vecs[c].n))));
    end

    // Backpressure: idx_ready low for three cycles
    match_lines = mk_ml(v149);
    load        = 1'b1;
    idx_ready   = 1'b0;
    tick();
    load        = 1'b0;
    match_lines = '1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(idx_valid), 1);
      chk($sformatf("bp_idx%0d", k), 32'(resp_idx), 1);
      if (k < 2) tick();
    end
    idx_ready = 1'b1;
    tick();
    chk("bp_idx4", 32'(resp_idx), 4);
    tick();
    chk("bp_idx99", 32'(resp_idx), 99);
    tick();
    chk("bp_done", 32'(done), 1);
    tick();
    chk("bp_idle", 32'(busy), 0);

    // Load with all-zero match lines during scan must be ignored
    match_lines = mk_ml(v149);
    load        = 1'b1;
    tick();
    match_lines = '0;
    chk("ls_idx1", 32'(resp_idx), 1);
    tick();
    chk("ls_idx4", 32'(resp_idx), 4);
    tick();
    chk("ls_idx99", 32'(resp_idx), 99);
    load        = 1'b0;
    match_lines = '1;
    tick();
    chk("ls_done", 32'(done), 1);
    chk("ls_count", 32'(resp_count), 32'(exp_cnt(3)));
    tick();
    chk("ls_idle", 32'(busy), 0);
    chk("ls_count_hold", 32'(resp_count), 32'(exp_cnt(3)));

    // Reset after index 4 is accepted
    match_lines = mk_ml(v149);
    load        = 1'b1;
    tick();
    load        = 1'b0;
    match_lines = '1;
    chk("rm_idx1", 32'(resp_idx), 1);
    tick();
    chk("rm_idx4", 32'(resp_idx), 4);
    tick();
    chk("rm_idx99_pre", 32'(resp_idx), 99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_valid", 32'(idx_valid), 0);
    chk("rm_count", 32'(resp_count), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rm_nodone%0d", k), 32'(done), 0);
      chk($sformatf("rm_novalid%0d", k), 32'(idx_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
